// File: rtl/retire_store_buffer_param.sv
// Post-retirement store buffer: circular FIFO of retired stores, drained to memory, with byte-wise store-to-load forwarding.
// Latency: an entry written in cycle N is visible to memory and forwarding from cycle N+1. Forwarding is combinational.
// Backpressure: the head is held stable while mem_req_ready=0. Writes beyond the free slots are dropped and set a sticky overflow flag.
//
// Ports:
//   i_clock, i_reset      clock and async active-high reset
//   i_wr_*                RETIRE_W retire lanes; lane 0 is the oldest
//   o_mem_req_*           head entry; handshake with i_mem_req_ready
//   i_ld_addr             LD_PORTS load byte addresses
//   o_ld_*                forwarded data, per-byte hits and full-word hit
//   o_count, o_empty, o_full, o_almost_full, o_overflow   occupancy and status
module retire_store_buffer_param #(
  parameter int DEPTH       = 8,
  parameter int RETIRE_W    = 2,
  parameter int LD_PORTS    = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int AFULL_SLACK = 2
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic [RETIRE_W-1:0]              i_wr_en,
  input  logic [RETIRE_W*ADDR_W-1:0]       i_wr_addr,
  input  logic [RETIRE_W*DATA_W-1:0]       i_wr_data,
  input  logic [RETIRE_W*(DATA_W/8)-1:0]   i_wr_mask,
  output logic                             o_mem_req_valid,
  output logic [ADDR_W-1:0]                o_mem_req_addr,
  output logic [DATA_W-1:0]                o_mem_req_data,
  output logic [DATA_W/8-1:0]              o_mem_req_mask,
  input  logic                             i_mem_req_ready,
  input  logic [LD_PORTS*ADDR_W-1:0]       i_ld_addr,
  output logic [LD_PORTS*DATA_W-1:0]       o_ld_data,
  output logic [LD_PORTS*(DATA_W/8)-1:0]   o_ld_byte_hit,
  output logic [LD_PORTS-1:0]              o_ld_full_hit,
  output logic [$clog2(DEPTH):0]           o_count,
  output logic                             o_empty,
  output logic                             o_full,
  output logic                             o_almost_full,
  output logic                             o_overflow
);

  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int WA  = ADDR_W - OFF;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  // Entry storage. The word address drops the byte-offset bits.
  logic [WA-1:0]     r_waddr [DEPTH];
  logic [DATA_W-1:0] r_data  [DEPTH];
  logic [NB-1:0]     r_mask  [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              r_overflow;

  logic              w_pop;
  logic              w_full;
  logic [CW-1:0]     w_free;
  logic [CW-1:0]     w_nacc;
  logic              w_drop;
  logic [RETIRE_W-1:0] w_acc;
  logic [PW-1:0]     w_slot [RETIRE_W];

  // Byte-offset address bits carry no information for word-granular storage.
  logic [(RETIRE_W+LD_PORTS)*OFF-1:0] w_unused_low_bits;
  always_comb begin
    w_unused_low_bits = '0;
    for (int l = 0; l < RETIRE_W; l++)
      w_unused_low_bits[l*OFF +: OFF] = i_wr_addr[l*ADDR_W +: OFF];
    for (int p = 0; p < LD_PORTS; p++)
      w_unused_low_bits[(RETIRE_W+p)*OFF +: OFF] = i_ld_addr[p*ADDR_W +: OFF];
  end

  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = (r_count != '0) && i_mem_req_ready;

  // Lane compaction. Acceptance is limited to the slots free at the start of
  // the cycle; the one exception is a full buffer that is also popping, where
  // the departing head slot (== tail) is refilled so occupancy holds at DEPTH.
  always_comb begin
    w_free = CW'(DEPTH) - r_count + CW'(w_full & w_pop);
    w_nacc = '0;
    w_drop = 1'b0;
    w_acc  = '0;
    for (int l = 0; l < RETIRE_W; l++) begin
      w_slot[l] = r_tail + w_nacc[PW-1:0];
      if (i_wr_en[l]) begin
        if (w_nacc < w_free) begin
          w_acc[l] = 1'b1;
          w_nacc   = w_nacc + CW'(1);
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_valid    <= '0;
    end else begin
      if (w_pop) r_valid[r_head] <= 1'b0;
      // Set after clear so a refill of the popped slot keeps it valid.
      for (int l = 0; l < RETIRE_W; l++)
        if (w_acc[l]) r_valid[w_slot[l]] <= 1'b1;
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + w_nacc[PW-1:0];
      r_count <= r_count + w_nacc - CW'(w_pop);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Payload needs no reset; r_valid qualifies every use.
  always_ff @(posedge i_clock) begin
    for (int l = 0; l < RETIRE_W; l++) begin
      if (w_acc[l]) begin
        r_waddr[w_slot[l]] <= i_wr_addr[l*ADDR_W+OFF +: WA];
        r_data[w_slot[l]]  <= i_wr_data[l*DATA_W +: DATA_W];
        r_mask[w_slot[l]]  <= i_wr_mask[l*NB +: NB];
      end
    end
  end

  assign o_mem_req_valid = (r_count != '0);
  assign o_mem_req_addr  = {r_waddr[r_head], {OFF{1'b0}}};
  assign o_mem_req_data  = r_data[r_head];
  assign o_mem_req_mask  = r_mask[r_head];
  assign o_count         = r_count;
  assign o_empty         = (r_count == '0);
  assign o_full          = w_full;
  assign o_almost_full   = (DEPTH - int'(r_count)) <= AFULL_SLACK;
  assign o_overflow      = r_overflow;

  // Forwarding: scan from oldest (tail-DEPTH) to youngest (tail-1) so the
  // youngest matching byte is the last one written. Ages are tail-relative.
  always_comb begin
    logic [PW-1:0] v_idx;
    logic [WA-1:0] v_wa;
    o_ld_data     = '0;
    o_ld_byte_hit = '0;
    v_idx         = '0;
    v_wa          = '0;
    for (int p = 0; p < LD_PORTS; p++) begin
      v_wa = i_ld_addr[p*ADDR_W+OFF +: WA];
      for (int k = DEPTH; k >= 1; k--) begin
        v_idx = r_tail - PW'(k);
        if (r_valid[v_idx] && (r_waddr[v_idx] == v_wa)) begin
          for (int b = 0; b < NB; b++) begin
            if (r_mask[v_idx][b]) begin
              o_ld_data[p*DATA_W+8*b +: 8] = r_data[v_idx][8*b +: 8];
              o_ld_byte_hit[p*NB+b]        = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    o_ld_full_hit = '0;
    for (int p = 0; p < LD_PORTS; p++)
      o_ld_full_hit[p] = &o_ld_byte_hit[p*NB +: NB];
  end

endmodule

// File: tb/tb_retire_store_buffer_param.sv
// Bench for retire_store_buffer_param (DEPTH=8, RETIRE_W=2, LD_PORTS=2, 32-bit).
// A queue-based model tracks buffer contents; a vector table and directed
// sequences cover drain order, forwarding merge, overflow, wrap and async reset.
module tb_retire_store_buffer_param;

  logic        clk;
  logic        rst;
  logic [1:0]  wr_en;
  logic [63:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_mask;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        rdy;
  logic [63:0] ld_addr;
  logic [63:0] ld_data;
  logic [7:0]  ld_byte_hit;
  logic [1:0]  ld_full_hit;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic        overflow;

  retire_store_buffer_param dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_wr_en         (wr_en),
    .i_wr_addr       (wr_addr),
    .i_wr_data       (wr_data),
    .i_wr_mask       (wr_mask),
    .o_mem_req_valid (mem_req_valid),
    .o_mem_req_addr  (mem_req_addr),
    .o_mem_req_data  (mem_req_data),
    .o_mem_req_mask  (mem_req_mask),
    .i_mem_req_ready (rdy),
    .i_ld_addr       (ld_addr),
    .o_ld_data       (ld_data),
    .o_ld_byte_hit   (ld_byte_hit),
    .o_ld_full_hit   (ld_full_hit),
    .o_count         (count),
    .o_empty         (empty),
    .o_full          (full),
    .o_almost_full   (almost_full),
    .o_overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
    logic [3:0]  m;
  } ent_t;

  ent_t q[$];
  bit   m_ovf;

  function automatic void mfwd(input logic [31:0] a, output logic [31:0] d, output logic [3:0] h);
    d = '0;
    h = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].wa == a[31:2] && q[i].m[b]) begin
          d[8*b +: 8] = q[i].d[8*b +: 8];
          h[b] = 1'b1;
          break;
        end
      end
    end
  endfunction

  // Applies one clock edge of the current inputs to the model.
  task automatic model_clock();
    ent_t nw[$];
    ent_t e;
    int   free;
    bit   pop;
    pop  = (q.size() != 0) && rdy;
    free = 8 - q.size();
    if (q.size() == 8 && pop) free = 1;
    for (int l = 0; l < 2; l++) begin
      if (wr_en[l]) begin
        if (free > 0) begin
          e.wa = wr_addr[32*l+2 +: 30];
          e.d  = wr_data[32*l +: 32];
          e.m  = wr_mask[4*l +: 4];
          nw.push_back(e);
          free--;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    if (pop) void'(q.pop_front());
    foreach (nw[i]) q.push_back(nw[i]);
  endtask

  task automatic check_model();
    logic [31:0] d;
    logic [3:0]  h;
    chk("count", 64'(count), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("full", 64'(full), 64'(q.size() == 8));
    chk("almost_full", 64'(almost_full), 64'((8 - q.size()) <= 2));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("mem_req_valid", 64'(mem_req_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("mem_req_addr", 64'(mem_req_addr), 64'({q[0].wa, 2'b00}));
      chk("mem_req_data", 64'(mem_req_data), 64'(q[0].d));
      chk("mem_req_mask", 64'(mem_req_mask), 64'(q[0].m));
    end
    for (int p = 0; p < 2; p++) begin
      mfwd(ld_addr[32*p +: 32], d, h);
      chk($sformatf("ld_data[%0d]", p), 64'(ld_data[32*p +: 32]), 64'(d));
      chk($sformatf("ld_byte_hit[%0d]", p), 64'(ld_byte_hit[4*p +: 4]), 64'(h));
      chk($sformatf("ld_full_hit[%0d]", p), 64'(ld_full_hit[p]), 64'(&h));
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clr_in();
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    wr_mask = '0;
    rdy     = 1'b0;
  endtask

  task automatic set_lane(input int l, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_en[l]           = 1'b1;
    wr_addr[32*l +: 32] = a;
    wr_data[32*l +: 32] = d;
    wr_mask[4*l +: 4]   = m;
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step();
    #1;
    check_model();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    clr_in();
    ld_addr = '0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    check_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  wr_en;
    logic [31:0] a0, d0;
    logic [3:0]  m0;
    logic [31:0] a1, d1;
    logic [3:0]  m1;
    logic        rdy;
    logic [31:0] la0, la1;
    logic [3:0]  ecnt;
    logic        evld;
    logic [31:0] eaddr;
    logic [31:0] ed0;
    logic [3:0]  eh0;
    logic [31:0] ed1;
    logic [3:0]  eh1;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [31:0] fd;
    // Expectations are the outputs seen with the row's inputs, before its clock edge.
    tbl[0]  = '{2'b01, 32'h100, 32'h1, 4'hF, 0, 0, 0, 0, 32'h100, 32'h100, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{2'b01, 32'h104, 32'h2, 4'hF, 0, 0, 0, 0, 32'h100, 32'h104, 1, 1, 32'h100, 32'h1, 4'hF, 0, 0};
    tbl[2]  = '{2'b01, 32'h108, 32'h3, 4'hF, 0, 0, 0, 0, 32'h100, 32'h104, 2, 1, 32'h100, 32'h1, 4'hF, 32'h2, 4'hF};
    tbl[3]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h108, 32'h10C, 3, 1, 32'h100, 32'h3, 4'hF, 0, 0};
    tbl[4]  = '{2'b00, 0, 0, 0, 0, 0, 0, 1, 32'h100, 32'h100, 3, 1, 32'h100, 32'h1, 4'hF, 32'h1, 4'hF};
    tbl[5]  = '{2'b00, 0, 0, 0, 0, 0, 0, 1, 32'h100, 32'h104, 2, 1, 32'h104, 0, 0, 32'h2, 4'hF};
    tbl[6]  = '{2'b00, 0, 0, 0, 0, 0, 0, 1, 32'h108, 32'h104, 1, 1, 32'h108, 32'h3, 4'hF, 0, 0};
    tbl[7]  = '{2'b10, 0, 0, 0, 32'h200, 32'hAABBCCDD, 4'hF, 1, 32'h202, 32'h202, 0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h202, 32'h203, 1, 1, 32'h200, 32'hAABBCCDD, 4'hF, 32'hAABBCCDD, 4'hF};
    tbl[9]  = '{2'b01, 32'h300, 32'h11223344, 4'hF, 0, 0, 0, 1, 32'h300, 32'h200, 1, 1, 32'h200, 0, 0, 32'hAABBCCDD, 4'hF};
    tbl[10] = '{2'b01, 32'h300, 32'h000000EE, 4'h1, 0, 0, 0, 0, 32'h300, 32'h200, 1, 1, 32'h300, 32'h11223344, 4'hF, 0, 0};
    tbl[11] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h300, 32'h304, 2, 1, 32'h300, 32'h112233EE, 4'hF, 0, 0};
    tbl[12] = '{2'b00, 0, 0, 0, 0, 0, 0, 1, 32'h301, 32'h300, 2, 1, 32'h300, 32'h112233EE, 4'hF, 32'h112233EE, 4'hF};
    tbl[13] = '{2'b00, 0, 0, 0, 0, 0, 0, 1, 32'h300, 32'h300, 1, 1, 32'h300, 32'h000000EE, 4'h1, 32'h000000EE, 4'h1};
    tbl[14] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h300, 32'h300, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1;
    clr_in();
    ld_addr = '0;
    q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    hard_reset();

    // Drain order, dual-lane compaction, byte-merge forwarding.
    for (int i = 0; i < 15; i++) begin
      clr_in();
      if (tbl[i].wr_en[0]) set_lane(0, tbl[i].a0, tbl[i].d0, tbl[i].m0);
      if (tbl[i].wr_en[1]) set_lane(1, tbl[i].a1, tbl[i].d1, tbl[i].m1);
      rdy     = tbl[i].rdy;
      ld_addr = {tbl[i].la1, tbl[i].la0};
      #1;
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_valid", i), 64'(mem_req_valid), 64'(tbl[i].evld));
      if (tbl[i].evld) chk($sformatf("tbl%0d_addr", i), 64'(mem_req_addr), 64'(tbl[i].eaddr));
      chk($sformatf("tbl%0d_ld0_data", i), 64'(ld_data[31:0]), 64'(tbl[i].ed0));
      chk($sformatf("tbl%0d_ld0_hit", i), 64'(ld_byte_hit[3:0]), 64'(tbl[i].eh0));
      chk($sformatf("tbl%0d_ld1_data", i), 64'(ld_data[63:32]), 64'(tbl[i].ed1));
      chk($sformatf("tbl%0d_ld1_hit", i), 64'(ld_byte_hit[7:4]), 64'(tbl[i].eh1));
      step();
    end

    // Fill to 7, overflow on a dual write, then dual write + pop while full.
    hard_reset();
    for (int i = 0; i < 7; i++) begin
      clr_in();
      set_lane(0, 32'h700 + 32'(4*i), 32'(i), 4'hF);
      step();
    end
    clr_in();
    #1;
    chk("fill7_count", 64'(count), 64'd7);
    chk("fill7_afull", 64'(almost_full), 64'd1);
    chk("fill7_full", 64'(full), 64'd0);
    set_lane(0, 32'h720, 32'hC0DE0000, 4'hF);
    set_lane(1, 32'h724, 32'hC0DE0001, 4'hF);
    step();
    clr_in();
    ld_addr = {32'h724, 32'h720};
    #1;
    chk("ovf_count", 64'(count), 64'd8);
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_lane0_hit", 64'(ld_byte_hit[3:0]), 64'hF);
    chk("ovf_lane1_dropped", 64'(ld_byte_hit[7:4]), 64'h0);
    set_lane(0, 32'h730, 32'hC0DE0002, 4'hF);
    set_lane(1, 32'h734, 32'hC0DE0003, 4'hF);
    rdy = 1'b1;
    step();
    clr_in();
    ld_addr = {32'h734, 32'h730};
    #1;
    chk("fullpop_count", 64'(count), 64'd8);
    chk("fullpop_ovf", 64'(overflow), 64'd1);
    chk("fullpop_head", 64'(mem_req_addr), 64'h704);
    chk("fullpop_in_hit", 64'(ld_byte_hit[3:0]), 64'hF);
    chk("fullpop_drop_hit", 64'(ld_byte_hit[7:4]), 64'h0);

    // Drain to 5, then assert reset between clock edges.
    for (int i = 0; i < 3; i++) begin
      clr_in();
      rdy = 1'b1;
      step();
    end
    clr_in();
    ld_addr = {32'h730, 32'h714};
    #1;
    chk("pre_arst_count", 64'(count), 64'd5);
    chk("pre_arst_hit", 64'(ld_byte_hit), 64'hFF);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(mem_req_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_ovf", 64'(overflow), 64'd0);
    chk("arst_hits", 64'(ld_byte_hit), 64'h0);
    chk("arst_data", 64'(ld_data), 64'h0);
    q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Wrap twice: older 0x400 lands at index 7, younger (low 2 bytes) at index 1.
    hard_reset();
    for (int i = 0; i < 15; i++) begin
      clr_in();
      set_lane(0, 32'h500 + 32'(4*i), 32'(i), 4'hF);
      rdy = 1'b1;
      step();
    end
    clr_in();
    set_lane(0, 32'h400, 32'hAAAAAAAA, 4'hF);
    step();
    clr_in();
    set_lane(0, 32'h540, 32'h55555555, 4'hF);
    step();
    clr_in();
    set_lane(0, 32'h400, 32'h0000BBBB, 4'h3);
    step();
    clr_in();
    ld_addr = {32'h401, 32'h400};
    #1;
    chk("wrap_ld0_data", 64'(ld_data[31:0]), 64'hAAAABBBB);
    chk("wrap_ld0_hit", 64'(ld_byte_hit[3:0]), 64'hF);
    chk("wrap_ld1_data", 64'(ld_data[63:32]), 64'hAAAABBBB);
    chk("wrap_full_hit", 64'(ld_full_hit), 64'h3);
    step();

    // Randomized traffic against the model.
    hard_reset();
    for (int n = 0; n < 400; n++) begin
      clr_in();
      for (int l = 0; l < 2; l++) begin
        if ($urandom_range(0, 2) != 0) begin
          fd = $urandom;
          set_lane(l, 32'h800 + 32'(4*$urandom_range(0, 7)) + 32'($urandom_range(0, 3)),
                   fd, 4'($urandom_range(0, 15)));
        end
      end
      rdy = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      ld_addr[31:0]  = 32'h800 + 32'(4*$urandom_range(0, 8)) + 32'($urandom_range(0, 3));
      ld_addr[63:32] = ($urandom_range(0, 3) == 0) ? ld_addr[31:0]
                       : 32'h800 + 32'(4*$urandom_range(0, 8));
      step();
    end
    clr_in();
    #1;
    check_model();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
